// File: rtl/joydir_pkg.sv
// Shared types and helpers for the multi-player direction arbiter: direction codes,
// resolution modes, the per-player press-order stack and its update functions.
package joydir_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        UP    = 2'd3
    } dir_code_t;

    typedef enum logic [1:0] {
        MODE_LAST     = 2'd0,
        MODE_FIRST    = 2'd1,
        MODE_NEUTRAL  = 2'd2,
        MODE_LAST_ALT = 2'd3
    } mode_t;

    localparam int STACK_DEPTH = 4;

    // ent[0] is the oldest held direction, ent[cnt-1] the newest.
    typedef struct packed {
        dir_code_t [STACK_DEPTH-1:0] ent;
        logic [2:0]                  cnt;
    } stack_t;

    function automatic logic [3:0] code_to_onehot(dir_code_t c);
        return 4'b0001 << c;
    endfunction

    function automatic dir_code_t onehot_to_code(logic [3:0] oh);
        dir_code_t c;
        c = RIGHT;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) c = dir_code_t'(2'(i));
        end
        return c;
    endfunction

    // Quarter-turn for rotated cabinets: raw up reads as left, left as down,
    // down as right, right as up.
    function automatic logic [3:0] rotate_map(logic [3:0] d);
        return {d[0], d[1], d[3], d[2]};
    endfunction

    function automatic logic [3:0] neutral_filter(logic [3:0] d);
        logic [3:0] v;
        v = d;
        if (d[3] && d[2]) v[3:2] = 2'b00;
        if (d[1] && d[0]) v[1:0] = 2'b00;
        return v;
    endfunction

    function automatic stack_t stack_remove(stack_t s, dir_code_t d);
        stack_t     r;
        logic [2:0] k;
        r = '0;
        k = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (3'(i) < s.cnt && s.ent[i] != d) begin
                r.ent[k[1:0]] = s.ent[i];
                k = k + 3'd1;
            end
        end
        r.cnt = k;
        return r;
    endfunction

    // Removing first keeps every code unique, so a re-press just moves it to the top.
    function automatic stack_t stack_push(stack_t s, dir_code_t d);
        stack_t r;
        r = stack_remove(s, d);
        if (r.cnt < 3'd4) begin
            r.ent[r.cnt[1:0]] = d;
            r.cnt = r.cnt + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/joydir_stack.sv
// Press-order history for one player: releases are removed first, then presses are
// pushed in ascending bit order so the higher index wins when presses coincide.
module joydir_stack
    import joydir_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic [3:0] press_vec,
    input  logic [3:0] release_vec,
    output logic [1:0] top_code,
    output logic [1:0] bottom_code,
    output logic       empty
);

    stack_t st;
    stack_t st_nxt;

    always_comb begin
        st_nxt = st;
        for (int d = 0; d < 4; d++) begin
            if (release_vec[d]) st_nxt = stack_remove(st_nxt, dir_code_t'(2'(d)));
        end
        for (int d = 0; d < 4; d++) begin
            if (press_vec[d]) st_nxt = stack_push(st_nxt, dir_code_t'(2'(d)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= '0;
        end else if (flush) begin
            st <= '0;
        end else begin
            st <= st_nxt;
        end
    end

    // With cnt == 4 the low bits wrap to 0, so minus one still lands on entry 3.
    assign top_code    = st.ent[st.cnt[1:0] - 2'd1];
    assign bottom_code = st.ent[0];
    assign empty       = (st.cnt == 3'd0);

endmodule

// File: rtl/joy_dir_arbiter.sv
// Multi-player direction arbiter with SOCD resolution and press-order fallback.
// Define JOYDIR_DEBOUNCE_EN to add a per-bit ce-driven debounce in front of the filter.
module joy_dir_arbiter
    import joydir_pkg::*;
#(
    parameter int               PLAYERS = 2,
    parameter int               DEB_W   = 16,
    parameter logic [DEB_W-1:0] DEB_CNT = 16'd500
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic [1:0]             mode,
    input  logic                   rotate,
    input  logic [PLAYERS*4-1:0]   dir_in,
    output logic [PLAYERS*4-1:0]   dir_out,
    output logic [PLAYERS-1:0]     change
);

    localparam int W = PLAYERS * 4;

    logic [W-1:0]       sync_a;
    logic [W-1:0]       sync_b;
    logic [W-1:0]       filt_in;
    logic [W-1:0]       filt;
    logic [W-1:0]       filt_d;
    logic [W-1:0]       press;
    logic [W-1:0]       rel;
    logic [W-1:0]       dir_nxt;
    logic [PLAYERS-1:0] change_nxt;
    logic               rotate_q;
    logic               rot_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a   <= '0;
            sync_b   <= '0;
            rotate_q <= 1'b0;
        end else begin
            sync_a   <= dir_in;
            sync_b   <= sync_a;
            rotate_q <= rotate;
        end
    end

    assign rot_flush = rotate ^ rotate_q;

`ifdef JOYDIR_DEBOUNCE_EN
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_CNT - DEB_W'(1);

    logic [DEB_W-1:0] deb_cnt [W];

    // A bit only moves once its new level has been seen on DEB_CNT consecutive ce ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int i = 0; i < W; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (filt_in[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (ce) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        filt[i]    <= filt_in[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end
            end
        end
    end
`else
    logic unused_deb;
    assign unused_deb = ^{ce, DEB_CNT};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
        end else begin
            filt <= filt_in;
        end
    end
`endif

    // Clearing filt_d on a rotate toggle makes every held bit re-enter as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d <= '0;
        end else begin
            filt_d <= rot_flush ? '0 : filt;
        end
    end

    assign press = filt & ~filt_d;
    assign rel   = ~filt & filt_d;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [1:0] top_code;
        logic [1:0] bottom_code;
        logic       empty;
        logic [3:0] nxt;

        assign filt_in[4*p +: 4] = rotate ? rotate_map(sync_b[4*p +: 4]) : sync_b[4*p +: 4];

        joydir_stack u_stack (
            .clk         (clk),
            .reset_n     (reset_n),
            .flush       (rot_flush),
            .press_vec   (press[4*p +: 4]),
            .release_vec (rel[4*p +: 4]),
            .top_code    (top_code),
            .bottom_code (bottom_code),
            .empty       (empty)
        );

        always_comb begin
            nxt = '0;
            case (mode_t'(mode))
                MODE_FIRST:   if (!empty) nxt = code_to_onehot(dir_code_t'(bottom_code));
                MODE_NEUTRAL: nxt = neutral_filter(filt_d[4*p +: 4]);
                default:      if (!empty) nxt = code_to_onehot(dir_code_t'(top_code));
            endcase
        end

        assign dir_nxt[4*p +: 4] = nxt;
        assign change_nxt[p]     = (nxt != dir_out[4*p +: 4]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_out <= '0;
            change  <= '0;
        end else begin
            dir_out <= dir_nxt;
            change  <= change_nxt;
        end
    end

endmodule

// File: tb/tb_joy_dir_arbiter.sv
// Scoreboard bench for joy_dir_arbiter: each scenario queues the dir_out/change it
// expects at a given cycle and compares when that cycle's output is visible.
module tb_joy_dir_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic [1:0] mode;
    logic       rotate;
    logic [7:0] dir_in;
    logic [7:0] dir_out;
    logic [1:0] change;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    typedef struct {
        int         due;
        logic [7:0] dir;
        logic [1:0] chg;
        string      tag;
    } exp_t;

    exp_t sb[$];

    joy_dir_arbiter #(
        .PLAYERS (2),
        .DEB_W   (16),
        .DEB_CNT (16'd4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .mode    (mode),
        .rotate  (rotate),
        .dir_in  (dir_in),
        .dir_out (dir_out),
        .change  (change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_after(input int dly, input logic [7:0] d, input logic [1:0] c,
                                input string tag);
        exp_t e;
        e.due = cyc + dly;
        e.dir = d;
        e.chg = c;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (dir_out !== 8'h00 || change !== 2'b00)
            $display("[TB] FAIL reset_state: dir_out=%b change=%b, expected 00000000 00", dir_out, change);
        else passed++;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (dir_out !== 8'h00 || change !== 2'b00)
            $display("[TB] FAIL idle_after_reset: dir_out=%b change=%b, expected 00000000 00", dir_out, change);
        else passed++;
    endtask

    task automatic test_last_fallback();
        exp_t e;
        mode = 2'd0;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dir_out !== e.dir || change !== e.chg)
                    $display("[TB] FAIL %s: dir_out=%b change=%b, expected dir_out=%b change=%b",
                             e.tag, dir_out, change, e.dir, e.chg);
                else passed++;
            end
            case (t)
                0: begin
                    dir_in = 8'h02;
                    expect_after(5, 8'h02, 2'b01, "last_left");
                    expect_after(6, 8'h02, 2'b00, "last_left_hold");
                end
                3: begin
                    dir_in = 8'h0A;
                    expect_after(5, 8'h08, 2'b01, "last_up");
                end
                10: begin
                    dir_in = 8'h02;
                    expect_after(5, 8'h02, 2'b01, "last_fallback");
                end
                16: begin
                    dir_in = 8'h00;
                    expect_after(5, 8'h00, 2'b01, "last_release");
                end
                default: ;
            endcase
        end
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL last_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_first();
        exp_t e;
        for (int t = 0; t < 22; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dir_out !== e.dir || change !== e.chg)
                    $display("[TB] FAIL %s: dir_out=%b change=%b, expected dir_out=%b change=%b",
                             e.tag, dir_out, change, e.dir, e.chg);
                else passed++;
            end
            case (t)
                0: begin
                    mode   = 2'd1;
                    dir_in = 8'h01;
                    expect_after(5, 8'h01, 2'b01, "first_right");
                end
                3: begin
                    dir_in = 8'h05;
                    expect_after(5, 8'h01, 2'b00, "first_hold");
                end
                8: begin
                    dir_in = 8'h04;
                    expect_after(5, 8'h04, 2'b01, "first_fallback");
                end
                14: begin
                    dir_in = 8'h00;
                    expect_after(5, 8'h00, 2'b01, "first_release");
                end
                default: ;
            endcase
        end
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL first_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_neutral();
        exp_t e;
        for (int t = 0; t < 26; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dir_out !== e.dir || change !== e.chg)
                    $display("[TB] FAIL %s: dir_out=%b change=%b, expected dir_out=%b change=%b",
                             e.tag, dir_out, change, e.dir, e.chg);
                else passed++;
            end
            case (t)
                0: begin
                    mode   = 2'd2;
                    dir_in = 8'hD0;
                    expect_after(5, 8'h10, 2'b10, "neutral_updown");
                end
                6: begin
                    dir_in = 8'hB0;
                    expect_after(5, 8'h80, 2'b10, "neutral_leftright");
                end
                12: begin
                    dir_in = 8'h90;
                    expect_after(5, 8'h90, 2'b10, "neutral_diagonal");
                end
                18: begin
                    dir_in = 8'h00;
                    expect_after(5, 8'h00, 2'b10, "neutral_release");
                end
                default: ;
            endcase
        end
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL neutral_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous_mode();
        exp_t e;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dir_out !== e.dir || change !== e.chg)
                    $display("[TB] FAIL %s: dir_out=%b change=%b, expected dir_out=%b change=%b",
                             e.tag, dir_out, change, e.dir, e.chg);
                else passed++;
            end
            case (t)
                0: begin
                    mode   = 2'd0;
                    dir_in = 8'h0C;
                    expect_after(5, 8'h08, 2'b01, "simul_last");
                end
                8: begin
                    mode = 2'd1;
                    expect_after(1, 8'h04, 2'b01, "mode_to_first");
                end
                12: begin
                    mode = 2'd3;
                    expect_after(1, 8'h08, 2'b01, "mode3_as_last");
                end
                16: begin
                    dir_in = 8'h00;
                    expect_after(5, 8'h00, 2'b01, "simul_release");
                end
                default: ;
            endcase
        end
        mode = 2'd0;
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL simul_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_rotate_reset();
        exp_t e;
        mode = 2'd0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dir_out !== e.dir || change !== e.chg)
                    $display("[TB] FAIL %s: dir_out=%b change=%b, expected dir_out=%b change=%b",
                             e.tag, dir_out, change, e.dir, e.chg);
                else passed++;
            end
            case (t)
                0: begin
                    dir_in = 8'h02;
                    expect_after(5, 8'h02, 2'b01, "rot_left");
                end
                8: begin
                    rotate = 1'b1;
                    expect_after(2, 8'h00, 2'b01, "rot_flush");
                    expect_after(3, 8'h04, 2'b01, "rot_remap");
                end
                default: ;
            endcase
        end
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL rotate_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (dir_out !== 8'h00 || change !== 2'b00)
            $display("[TB] FAIL async_reset: dir_out=%b change=%b, expected 00000000 00", dir_out, change);
        else passed++;
        dir_in = 8'h00;
        rotate = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef JOYDIR_DEBOUNCE_EN
    task automatic test_debounce();
        exp_t e;
        mode = 2'd0;
        ce   = 1'b1;
        for (int t = 0; t < 28; t++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                total++;
                if (dir_out !== e.dir || change !== e.chg)
                    $display("[TB] FAIL %s: dir_out=%b change=%b, expected dir_out=%b change=%b",
                             e.tag, dir_out, change, e.dir, e.chg);
                else passed++;
            end
            case (t)
                0: begin
                    dir_in = 8'h08;
                    expect_after(8, 8'h00, 2'b00, "deb_glitch_a");
                end
                3: begin
                    dir_in = 8'h00;
                    expect_after(8, 8'h00, 2'b00, "deb_glitch_b");
                end
                12: begin
                    dir_in = 8'h08;
                    expect_after(7, 8'h00, 2'b00, "deb_not_early");
                    expect_after(8, 8'h08, 2'b01, "deb_up");
                end
                16: begin
                    dir_in = 8'h00;
                    expect_after(8, 8'h00, 2'b01, "deb_release");
                end
                default: ;
            endcase
        end
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL debounce_timeout: pending=%0d, expected 0", sb.size());
            sb.delete();
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        mode    = 2'd0;
        rotate  = 1'b0;
        dir_in  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_last_fallback();
        test_first();
        test_neutral();
        test_simultaneous_mode();
        test_rotate_reset();
`ifdef JOYDIR_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
